// File: rtl/pipelined_adder_subtractor_pkg.sv
// Shared definitions for the pipelined adder/subtractor: operation encoding,
// default geometry and the stage-count helper.
package pipelined_adder_subtractor_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_CHUNK = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int unsigned num_stages(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/pipelined_adder_subtractor_slice.sv
// Combinational CHUNK-bit ripple slice: sum, carry-out and carry into the slice MSB.
module adder_subtractor_slice #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b_eff,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] total;

  always_comb begin
    total = {1'b0, a} + {1'b0, b_eff} + (CHUNK+1)'(cin);
  end

  assign sum   = total[CHUNK-1:0];
  assign cout  = total[CHUNK];
  // Sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out by XOR.
  assign c_msb = total[CHUNK-1] ^ a[CHUNK-1] ^ b_eff[CHUNK-1];

endmodule

// File: rtl/pipelined_adder_subtractor.sv
// WIDTH-bit add/subtract unit pipelined in CHUNK-bit slices with a valid/ready
// handshake, global stall on backpressure and registered status flags.
module pipelined_adder_subtractor
  import pipelined_adder_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int unsigned STAGES = num_stages(WIDTH, CHUNK);

  if ((WIDTH % CHUNK) != 0 || WIDTH < CHUNK) begin : g_bad_geometry
    $error("WIDTH must be a non-zero multiple of CHUNK");
  end

  logic             advance_c;
  logic [WIDTH-1:0] b_eff_c;
  logic             cin_eff_c;

  // Per-stage inputs: what each stage sees from its predecessor.
  logic [STAGES-1:0]            st_vld;
  logic [STAGES-1:0][WIDTH-1:0] st_a;
  logic [STAGES-1:0][WIDTH-1:0] st_b;
  logic [STAGES-1:0][WIDTH-1:0] st_res;
  logic [STAGES-1:0]            st_cin;

  logic [STAGES-1:0][CHUNK-1:0] sum_w;
  logic [STAGES-1:0]            cout_w;
  logic [STAGES-1:0]            cmsb_w;

  logic [STAGES-1:0]            vld_q, vld_d;
  logic [STAGES-1:0][WIDTH-1:0] a_q, a_d;
  logic [STAGES-1:0][WIDTH-1:0] b_q, b_d;
  logic [STAGES-1:0][WIDTH-1:0] res_q, res_d;
  logic [STAGES-1:0]            cy_q, cy_d;
  logic                         ovf_q, ovf_d;
  logic                         zero_q, zero_d;
  logic                         neg_q, neg_d;

  logic unused_operands;

  always_comb begin
    advance_c = !vld_q[STAGES-1] || out_ready;
    b_eff_c   = b ^ {WIDTH{control == OP_SUB}};
    cin_eff_c = cin ^ (control == OP_SUB);
  end

  assign in_ready = advance_c;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign st_vld[k] = in_valid;
      assign st_a[k]   = a;
      assign st_b[k]   = b_eff_c;
      assign st_res[k] = '0;
      assign st_cin[k] = cin_eff_c;
    end else begin : g_rest
      assign st_vld[k] = vld_q[k-1];
      assign st_a[k]   = a_q[k-1];
      assign st_b[k]   = b_q[k-1];
      assign st_res[k] = res_q[k-1];
      assign st_cin[k] = cy_q[k-1];
    end

    adder_subtractor_slice #(
      .CHUNK(CHUNK)
    ) u_slice (
      .a     (st_a[k][k*CHUNK +: CHUNK]),
      .b_eff (st_b[k][k*CHUNK +: CHUNK]),
      .cin   (st_cin[k]),
      .sum   (sum_w[k]),
      .cout  (cout_w[k]),
      .c_msb (cmsb_w[k])
    );
  end

  // Next-state: hold everything on stall, shift the whole pipe on advance.
  always_comb begin
    vld_d  = vld_q;
    a_d    = a_q;
    b_d    = b_q;
    res_d  = res_q;
    cy_d   = cy_q;
    ovf_d  = ovf_q;
    zero_d = zero_q;
    neg_d  = neg_q;
    if (advance_c) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        vld_d[k] = st_vld[k];
        a_d[k]   = st_a[k];
        b_d[k]   = st_b[k];
        res_d[k] = st_res[k];
        res_d[k][k*CHUNK +: CHUNK] = sum_w[k];
        cy_d[k]  = cout_w[k];
      end
      ovf_d  = cmsb_w[STAGES-1] ^ cout_w[STAGES-1];
      zero_d = (res_d[STAGES-1] == '0);
      neg_d  = res_d[STAGES-1][WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      cy_q   <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      a_q    <= a_d;
      b_q    <= b_d;
      res_q  <= res_d;
      cy_q   <= cy_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
      neg_q  <= neg_d;
    end
  end

  // Consumed operand chunks and the last stage's operand copy have no reader.
  assign unused_operands = ^{a_q, b_q};

  assign out_valid = vld_q[STAGES-1];
  assign result    = res_q[STAGES-1];
  assign cout      = cy_q[STAGES-1];
  assign overflow  = ovf_q;
  assign zero      = zero_q;
  assign negative  = neg_q;

endmodule

// File: tb/tb_pipelined_adder_subtractor.sv
// Bench for pipelined_adder_subtractor (WIDTH=16, CHUNK=4): directed vectors,
// stall sequence, reset-in-flight sequence and randomized scoreboard checking.
module tb_pipelined_adder_subtractor;

  localparam int unsigned W = 16;
  localparam int unsigned LAT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cin;
  logic          control;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          cout;
  logic          overflow;
  logic          zero;
  logic          negative;

  pipelined_adder_subtractor #(.WIDTH(16), .CHUNK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .control   (control),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .overflow  (overflow),
    .zero      (zero),
    .negative  (negative)
  );

  always #5 clk = ~clk;

  typedef logic [19:0] exp_t;  // {result, cout, overflow, zero, negative}

  typedef struct {
    logic [W-1:0] av;
    logic [W-1:0] bv;
    logic         ci;
    logic         ct;
    logic [W-1:0] res;
    logic         co;
    logic         ov;
    logic         z;
    logic         n;
  } vec_t;

  vec_t vecs [7];
  exp_t sb [$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_popped = 0;
  logic stale_seen = 1'b0;
  logic hold_chk = 1'b0;
  logic [20:0] hold_val;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t outs();
    return {result, cout, overflow, zero, negative};
  endfunction

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic ci, input logic ct);
    int ua = int'(av);
    int ub = int'(bv);
    int sa = int'($signed(av));
    int sbv = int'($signed(bv));
    int c = int'(ci);
    int s;
    int sr;
    logic [W-1:0] r;
    logic co;
    logic ov;
    if (ct) begin
      s  = ua - ub - c;
      co = (s >= 0);
      sr = sa - sbv - c;
    end else begin
      s  = ua + ub + c;
      co = (s >= 65536);
      sr = sa + sbv + c;
    end
    r  = 16'(s);
    ov = (sr > 32767) || (sr < -32768);
    return {r, co, ov, (r == '0), r[W-1]};
  endfunction

  // One handshake cycle with scoreboard and stall-stability checks.
  task automatic step(input logic iv, input logic orr, input logic [W-1:0] av,
                      input logic [W-1:0] bv, input logic ci, input logic ct,
                      output logic acc);
    @(negedge clk);
    in_valid = iv; out_ready = orr; a = av; b = bv; cin = ci; control = ct;
    #1;
    if (hold_chk) check("stall_hold", 32'({out_valid, outs()}), 32'(hold_val));
    check("in_ready", 32'(in_ready), 32'(!out_valid || orr));
    acc = iv && in_ready;
    if (out_valid && orr) begin
      if (sb.size() == 0) begin
        stale_seen = 1'b1;
        check("spurious_out", 32'(1), 32'(0));
      end else begin
        check("result", 32'(outs()), 32'(sb.pop_front()));
        n_popped++;
      end
    end
    if (acc) sb.push_back(model(av, bv, ci, ct));
    hold_chk = out_valid && !orr;
    hold_val = {1'b1, outs()};
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1; a = v.av; b = v.bv; cin = v.ci; control = v.ct;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(LAT));
    check({tag, "_outputs"}, 32'(outs()), 32'({v.res, v.co, v.ov, v.z, v.n}));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic acc;
    int idx;
    int cyc;
    logic [W-1:0] ops_a [8];
    logic [W-1:0] ops_b [8];
    logic         ops_c [8];
    logic         ops_t [8];

    vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; control = 1'b0;
    #2;
    check("reset_outputs", 32'({out_valid, outs()}), 32'(0));
    check("reset_in_ready", 32'(in_ready), 32'(1));
    @(negedge clk);
    rst_n = 1'b1;

    // Directed single operations, one at a time.
    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Eight back-to-back ops with out_ready low for three cycles.
    for (int i = 0; i < 8; i++) begin
      ops_a[i] = 16'($urandom); ops_b[i] = 16'($urandom);
      ops_c[i] = 1'($urandom);  ops_t[i] = 1'($urandom);
    end
    idx = 0; cyc = 0; n_popped = 0;
    while (idx < 8 && cyc < 40) begin
      step(1'b1, !(cyc >= 6 && cyc <= 8), ops_a[idx], ops_b[idx], ops_c[idx], ops_t[idx], acc);
      if (acc) idx++;
      cyc++;
    end
    cyc = 0;
    while (sb.size() > 0 && cyc < 20) begin
      step(1'b0, 1'b1, '0, '0, 1'b0, 1'b0, acc);
      cyc++;
    end
    check("burst_issued", 32'(idx), 32'(8));
    check("burst_drained", 32'(sb.size()), 32'(0));
    check("burst_count", 32'(n_popped), 32'(8));

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] ra, rb;
      ra = ($urandom_range(0, 7) == 0) ? 16'h7FFF : 16'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? ra : 16'($urandom);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, ra, rb,
           1'($urandom), 1'($urandom), acc);
    end
    cyc = 0;
    while (sb.size() > 0 && cyc < 30) begin
      step(1'b0, 1'b1, '0, '0, 1'b0, 1'b0, acc);
      cyc++;
    end
    check("random_drained", 32'(sb.size()), 32'(0));

    // Reset with operations in flight.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 16'(i + 1), 16'h0100, 1'b0, 1'b0, acc);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("pre_reset_valid", 32'(out_valid), 32'(1));
    rst_n = 1'b0;
    #1;
    check("reset_flight_outputs", 32'({out_valid, outs()}), 32'(0));
    check("reset_flight_in_ready", 32'(in_ready), 32'(1));
    sb.delete();
    hold_chk = 1'b0;
    stale_seen = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, '0, '0, 1'b0, 1'b0, acc);
    check("no_stale_after_reset", 32'(stale_seen), 32'(0));
    run_vec(vecs[0], "post_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
